// File: rtl/mem_sram_port_pkg.sv
// mem_sram_port_pkg: shared state encodings and byte width for the SRAM request/response port.
package mem_sram_port_pkg;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/mem_sram_array.sv
// mem_sram_array: DEPTH x DATA_WIDTH storage, byte-enable synchronous write, registered read, no reset.
module mem_sram_array import mem_sram_port_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [DATA_WIDTH/BYTE_W-1:0]  i_be,
  input  logic                          i_re,
  input  logic [$clog2(DEPTH)-1:0]      i_addr,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  output logic [DATA_WIDTH-1:0]         o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH/BYTE_W; b++)
      if (i_we && i_be[b]) r_mem[i_addr][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
    if (i_re) o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/mem_sram_port.sv
// mem_sram_port: valid/ready SRAM port with latency-1 responses and range/alignment errors.
// Define MEM_SRAM_ZERO_INIT_EN to zero-fill the array (busy_o high) after every reset.
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif
module mem_sram_port import mem_sram_port_pkg::*; #(
  parameter int DATA_WIDTH = `API_DATA_WIDTH,
  parameter int ADDR_WIDTH = `API_ADDR_WIDTH,
  parameter int DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_WIDTH-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0]         req_wdata_i,
  input  logic [DATA_WIDTH/BYTE_W-1:0]  req_wmask_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          busy_o
);
  localparam int BW = DATA_WIDTH/BYTE_W;
  localparam int OFF = $clog2(BW);
  localparam int IW = $clog2(DEPTH);
  logic w_init, w_acc, w_err, w_wr, w_we, w_re;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [IW-1:0] w_addr;
  logic [BW-1:0] w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_rdata;
  logic r_rsp_valid, r_rsp_err, r_rsp_rd;
`ifdef MEM_SRAM_ZERO_INIT_EN
  logic [0:0] r_state;
  logic [IW-1:0] r_cnt;
  assign w_init = r_state == ST_INIT;
  assign w_addr = w_init ? r_cnt : w_word[IW-1:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_cnt <= '0;
    end else if (w_init) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == IW'(DEPTH-1)) r_state <= ST_RUN;
    end
`else
  assign w_init = 1'b0;
  assign w_addr = w_word[IW-1:0];
`endif
  assign w_word = req_addr_i >> OFF;
  assign w_err = (|(req_addr_i & ADDR_WIDTH'(BW-1))) || (w_word >= ADDR_WIDTH'(DEPTH));
  assign w_wr = |req_wmask_i;
  assign req_ready_o = reset_n && !w_init && (!r_rsp_valid || rsp_ready_i);
  assign w_acc = req_valid_i && req_ready_o;
  assign w_we = w_init || (w_acc && w_wr && !w_err);
  assign w_re = w_acc && !w_wr && !w_err;
  assign w_be = w_init ? '1 : req_wmask_i;
  assign w_wdata = w_init ? '0 : req_wdata_i;
  assign busy_o = w_init;
  // The array read register only loads on an accepted read, so it holds the word through a stall.
  assign rsp_rdata_o = r_rsp_rd ? w_rdata : '0;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o = r_rsp_err;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_rd <= 1'b0;
    end else if (w_acc) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err <= w_err;
      r_rsp_rd <= w_re;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_rd <= 1'b0;
    end
  mem_sram_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .i_we(w_we),
    .i_be(w_be),
    .i_re(w_re),
    .i_addr(w_addr),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );
endmodule

// File: tb/tb_mem_sram_port.sv
// tb_mem_sram_port: table-driven directed checks of mem_sram_port plus stall, stream and reset sequences.
module tb_mem_sram_port;
  logic clk = 1'b0;
  logic reset_n;
  logic req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
  logic [31:0] req_addr_i, req_wdata_i, rsp_rdata_o;
  logic [3:0] req_wmask_i;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic v;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0] m;
    logic rr;
    logic er;
    logic ev;
    logic [31:0] ed;
    logic ee;
  } vec_t;
  vec_t tbl[13];
  always #5 clk = ~clk;
  mem_sram_port dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // Drives one request cycle: ready is checked before the edge, the response after it.
  task automatic step(input string n, input vec_t t);
    req_valid_i = t.v;
    req_addr_i = t.a;
    req_wdata_i = t.d;
    req_wmask_i = t.m;
    rsp_ready_i = t.rr;
    #1;
    chk({n, ".ready"}, 32'(req_ready_o), 32'(t.er));
    @(posedge clk);
    #1;
    chk({n, ".valid"}, 32'(rsp_valid_o), 32'(t.ev));
    chk({n, ".rdata"}, rsp_rdata_o, t.ed);
    chk({n, ".err"}, 32'(rsp_err_o), 32'(t.ee));
  endtask
  task automatic count_init(output int n, output int acc);
    n = 0;
    acc = 0;
    for (int i = 0; i < 1000 && busy_o; i++) begin
      n++;
      if (req_ready_o) acc++;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk_reset(input string n);
    chk({n, ".ready"}, 32'(req_ready_o), 0);
    chk({n, ".valid"}, 32'(rsp_valid_o), 0);
    chk({n, ".rdata"}, rsp_rdata_o, 0);
    chk({n, ".err"}, 32'(rsp_err_o), 0);
`ifdef MEM_SRAM_ZERO_INIT_EN
    chk({n, ".busy"}, 32'(busy_o), 1);
`else
    chk({n, ".busy"}, 32'(busy_o), 0);
`endif
  endtask
  initial begin
    int n, acc;
    reset_n = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i = '0;
    req_wdata_i = '0;
    req_wmask_i = '0;
    rsp_ready_i = 1'b1;
    tbl[0]  = '{1, 32'h20,  32'hDEADBEEF, 4'hF, 1, 1, 1, 32'h0, 0};
    tbl[1]  = '{1, 32'h20,  32'h000000AA, 4'h1, 1, 1, 1, 32'h0, 0};
    tbl[2]  = '{1, 32'h20,  32'h0,        4'h0, 1, 1, 1, 32'hDEADBEAA, 0};
    tbl[3]  = '{1, 32'h400, 32'h0,        4'h0, 1, 1, 1, 32'h0, 1};
    tbl[4]  = '{1, 32'h22,  32'h0,        4'h0, 1, 1, 1, 32'h0, 1};
    tbl[5]  = '{1, 32'h22,  32'h12345678, 4'hF, 1, 1, 1, 32'h0, 1};
    tbl[6]  = '{1, 32'h20,  32'h0,        4'h0, 1, 1, 1, 32'hDEADBEAA, 0};
    tbl[7]  = '{1, 32'h3FC, 32'hCAFEF00D, 4'hF, 1, 1, 1, 32'h0, 0};
    tbl[8]  = '{1, 32'h3FC, 32'h0,        4'h0, 1, 1, 1, 32'hCAFEF00D, 0};
    tbl[9]  = '{1, 32'h24,  32'h11223344, 4'hF, 1, 1, 1, 32'h0, 0};
    tbl[10] = '{1, 32'h24,  32'hAABBCCDD, 4'hA, 1, 1, 1, 32'h0, 0};
    tbl[11] = '{1, 32'h24,  32'h0,        4'h0, 1, 1, 1, 32'hAA22CC44, 0};
    tbl[12] = '{0, 32'h0,   32'h0,        4'h0, 1, 1, 0, 32'h0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    reset_n = 1'b1;
`ifdef MEM_SRAM_ZERO_INIT_EN
    req_valid_i = 1'b1;
    req_addr_i = 32'h20;
    count_init(n, acc);
    chk("init_cycles", n, 256);
    chk("init_accepts", acc, 0);
    step("init_read", '{1, 32'h20, 32'h0, 4'h0, 1, 1, 1, 32'h0, 0});
`endif
    for (int i = 0; i < 13; i++) step($sformatf("vec%0d", i), tbl[i]);
    step("bp_rd", '{1, 32'h20, 32'h0, 4'h0, 1, 1, 1, 32'hDEADBEAA, 0});
    for (int i = 0; i < 3; i++)
      step($sformatf("bp_stall%0d", i), '{1, 32'h3FC, 32'h0, 4'h0, 0, 0, 1, 32'hDEADBEAA, 0});
    step("bp_release", '{1, 32'h3FC, 32'h0, 4'h0, 1, 1, 1, 32'hCAFEF00D, 0});
    for (int k = 0; k < 8; k++)
      step($sformatf("str_wr%0d", k), '{1, 32'h40 + 32'(4*k), 32'h1000 + 32'(k), 4'hF, 1, 1, 1, 32'h0, 0});
    for (int k = 0; k < 8; k++)
      step($sformatf("str_rd%0d", k), '{1, 32'h40 + 32'(4*k), 32'h0, 4'h0, 1, 1, 1, 32'h1000 + 32'(k), 0});
    step("idle", '{0, 32'h0, 32'h0, 4'h0, 1, 1, 0, 32'h0, 0});
    step("pend_rd", '{1, 32'h20, 32'h0, 4'h0, 0, 1, 1, 32'hDEADBEAA, 0});
    req_valid_i = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset("pend_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rsp_ready_i = 1'b1;
`ifdef MEM_SRAM_ZERO_INIT_EN
    req_valid_i = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_init_busy", 32'(busy_o), 1);
    reset_n = 1'b0;
    #1;
    chk_reset("init_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    count_init(n, acc);
    chk("reinit_cycles", n, 256);
    chk("reinit_accepts", acc, 0);
    step("post_rst_rd", '{1, 32'h20, 32'h0, 4'h0, 1, 1, 1, 32'h0, 0});
`else
    step("post_rst_rd", '{1, 32'h20, 32'h0, 4'h0, 1, 1, 1, 32'hDEADBEAA, 0});
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
